// File: rtl/sigan_pkg.sv
// sigan_pkg
// Shared definitions for the signature-analyzer path (sigan and sigan_source):
// signature width, feedback tap positions of x^16+x^12+x^9+x^7+1, the stimulus
// source state enum, and the one-bit signature shift helper.
// No ports.
package sigan_pkg;

  localparam int SIG_WIDTH = 16;

  // Feedback taps of the signature register, as bit indices.
  localparam int TAP_A = 6;
  localparam int TAP_B = 8;
  localparam int TAP_C = 11;
  localparam int TAP_D = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WINDOW = 2'd1,
    GAP    = 2'd2
  } state_e;

  // One shift of the signature register with data bit d entering at bit 0.
  function automatic logic [SIG_WIDTH-1:0] sig_shift(input logic [SIG_WIDTH-1:0] sig,
                                                     input logic                 d);
    return {sig[SIG_WIDTH-2:0], d ^ sig[TAP_A] ^ sig[TAP_B] ^ sig[TAP_C] ^ sig[TAP_D]};
  endfunction

endpackage

// File: rtl/sigan_lfsr_model.sv
// sigan_lfsr_model
// Single-channel signature model: a 16-bit shift register that folds one data
// bit per enabled clock into the running signature.
// Ports:
//   clock   - rising-edge clock
//   reset   - synchronous active-high reset, clears the signature
//   clear_i - treat the register as zero before this cycle's shift
//   en_i    - shift d_i in this cycle
//   d_i     - data bit for this channel
//   sig_o   - current signature
module sigan_lfsr_model
  import sigan_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear_i,
  input  logic                 en_i,
  input  logic                 d_i,
  output logic [SIG_WIDTH-1:0] sig_o
);

  logic [SIG_WIDTH-1:0] sig_q;
  logic [SIG_WIDTH-1:0] sig_d;

  // The clear and the first shift happen in the same cycle, so the start
  // cycle's bit lands in a freshly zeroed register.
  always_comb begin
    sig_d = sig_q;
    if (en_i) begin
      sig_d = sig_shift(clear_i ? '0 : sig_q, d_i);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/sigan_source.sv
// sigan_source
// Stimulus transmitter for the signature-analyzer path. Produces gate windows
// (start/stop strobes) with a binary counter on the data bus, optionally with
// per-channel reference signatures. Optional feature macro:
//   SIGAN_SOURCE_EXPECT_EN - compiles in the signature models; otherwise
//                            expected and expected_valid are tied to 0.
// Ports:
//   clock          - rising-edge clock
//   reset          - synchronous active-high reset
//   run            - level request to keep producing windows
//   start          - strobe on the first window cycle
//   stop           - strobe on the last window cycle
//   data           - counter value (DATA_WIDTH channels)
//   busy           - high from start through stop
//   done           - pulse the cycle after stop
//   expected       - per-channel signature, channel i at [16i+15:16i]
//   expected_valid - expected is final, from done until the next start
module sigan_source
  import sigan_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int WINDOW_LEN = 1024,
  parameter int GAP_LEN    = 1024,
  parameter int COUNT_INIT = 0
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            run,
  output logic                            start,
  output logic                            stop,
  output logic [DATA_WIDTH-1:0]           data,
  output logic                            busy,
  output logic                            done,
  output logic [SIG_WIDTH*DATA_WIDTH-1:0] expected,
  output logic                            expected_valid
);

  // One position counter serves both the window and the gap, so it is sized
  // for the longer of the two.
  localparam int MAX_LEN = (WINDOW_LEN > GAP_LEN) ? WINDOW_LEN : GAP_LEN;
  localparam int POS_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [POS_W-1:0]      WIN_LAST = POS_W'(WINDOW_LEN - 1);
  localparam logic [POS_W-1:0]      GAP_LAST = POS_W'(GAP_LEN - 1);
  localparam logic [POS_W-1:0]      POS_ONE  = POS_W'(1);
  localparam logic [DATA_WIDTH-1:0] INIT_VAL = DATA_WIDTH'(COUNT_INIT);
  localparam logic [DATA_WIDTH-1:0] CNT_ONE  = DATA_WIDTH'(1);

  state_e                state_q, state_d;
  logic [POS_W-1:0]      pos_q, pos_d;
  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic                  done_q, done_d;

  // Next-state logic. A window always runs to its stop cycle; run is only
  // consulted at the stop cycle and at the end of the gap. The counter is
  // reloaded on every transition into WINDOW.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (run) begin
          state_d = WINDOW;
          pos_d   = '0;
          cnt_d   = INIT_VAL;
        end
      end
      WINDOW: begin
        cnt_d = cnt_q + CNT_ONE;
        if (pos_q == WIN_LAST) begin
          done_d  = 1'b1;
          pos_d   = '0;
          state_d = run ? GAP : IDLE;
        end else begin
          pos_d = pos_q + POS_ONE;
        end
      end
      GAP: begin
        cnt_d = cnt_q + CNT_ONE;
        if (pos_q == GAP_LAST) begin
          pos_d = '0;
          if (run) begin
            state_d = WINDOW;
            cnt_d   = INIT_VAL;
          end else begin
            state_d = IDLE;
          end
        end else begin
          pos_d = pos_q + POS_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        pos_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      pos_q   <= '0;
      cnt_q   <= INIT_VAL;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign busy  = (state_q == WINDOW);
  assign start = busy && (pos_q == '0);
  assign stop  = busy && (pos_q == WIN_LAST);
  assign data  = cnt_q;
  assign done  = done_q;

`ifdef SIGAN_SOURCE_EXPECT_EN

  logic valid_q, valid_d;

  // Valid drops on the start cycle (the models are being rewritten) and rises
  // together with done, once the stop cycle's bit has been absorbed.
  always_comb begin
    valid_d = valid_q;
    if ((state_d == WINDOW) && (state_q != WINDOW)) begin
      valid_d = 1'b0;
    end else if (done_d) begin
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  for (genvar ch = 0; ch < DATA_WIDTH; ch++) begin : gModel
    sigan_lfsr_model uModel (
      .clock   (clock),
      .reset   (reset),
      .clear_i (start),
      .en_i    (busy),
      .d_i     (cnt_q[ch]),
      .sig_o   (expected[SIG_WIDTH*ch +: SIG_WIDTH])
    );
  end

  assign expected_valid = valid_q;

`else

  assign expected       = '0;
  assign expected_valid = 1'b0;

`endif

endmodule

// File: tb/tb_sigan_source.sv
// tb_sigan_source
// Drives several sigan_source instances (different window/gap lengths) from a
// shared run/reset and compares every output, every cycle, against a
// cycle-indexed behavioural model plus hand-computed literal expectations.
module tb_sigan_source;

  localparam int NI = 5;
  localparam int DW = 8;
  localparam int WLS [NI] = '{1, 2, 3, 8, 4};
  localparam int GLS [NI] = '{1, 3, 2, 2, 2};

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic run   = 1'b0;

  logic [NI-1:0]                startA, stopA, busyA, doneA, validA;
  logic [NI-1:0][DW-1:0]        dataA;
  logic [NI-1:0][16*DW-1:0]     expA;

  for (genvar g = 0; g < NI; g++) begin : gInst
    sigan_source #(
      .DATA_WIDTH (DW),
      .WINDOW_LEN (WLS[g]),
      .GAP_LEN    (GLS[g]),
      .COUNT_INIT (0)
    ) dut (
      .clock          (clock),
      .reset          (reset),
      .run            (run),
      .start          (startA[g]),
      .stop           (stopA[g]),
      .data           (dataA[g]),
      .busy           (busyA[g]),
      .done           (doneA[g]),
      .expected       (expA[g]),
      .expected_valid (validA[g])
    );
  end

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Model state per instance: idle flag, cycles since the last window start,
  // counter value, done / valid flags, and "nothing since reset".
  bit              mIdle  [NI];
  int              mPos   [NI];
  logic [DW-1:0]   mData  [NI];
  bit              mDone  [NI];
  bit              mValid [NI];
  bit              mFresh [NI];

  // Signature of channel ch over a window of wl cycles with data = 0,1,2,...
  function automatic logic [15:0] sigOf(input int wl, input int ch);
    logic [15:0]   s;
    logic [DW-1:0] v;
    logic          d;
    s = '0;
    for (int j = 0; j < wl; j++) begin
      v = j[DW-1:0];
      d = v[ch];
      s = {s[14:0], d ^ s[6] ^ s[8] ^ s[11] ^ s[15]};
    end
    return s;
  endfunction

  function automatic logic [16*DW-1:0] sigWord(input int wl);
    logic [16*DW-1:0] w;
    w = '0;
    for (int ch = 0; ch < DW; ch++) begin
      w[16*ch +: 16] = sigOf(wl, ch);
    end
    return w;
  endfunction

  // Model advance: what each instance must show in the cycle after this edge.
  always @(posedge clock) begin
    bit wasStop, wasGapEnd, starting;
    for (int i = 0; i < NI; i++) begin
      if (reset) begin
        mIdle[i]  = 1'b1;
        mPos[i]   = 0;
        mData[i]  = '0;
        mDone[i]  = 1'b0;
        mValid[i] = 1'b0;
        mFresh[i] = 1'b1;
      end else begin
        wasStop   = !mIdle[i] && (mPos[i] == WLS[i] - 1);
        wasGapEnd = !mIdle[i] && (mPos[i] == WLS[i] + GLS[i] - 1);
        starting  = 1'b0;
        mDone[i]  = wasStop;
        if (mIdle[i]) begin
          starting = run;
        end else begin
          mData[i] = mData[i] + 1'b1;
          if ((wasStop || wasGapEnd) && !run) mIdle[i] = 1'b1;
          else if (wasGapEnd) starting = 1'b1;
          else mPos[i] = mPos[i] + 1;
        end
        if (starting) begin
          mIdle[i]  = 1'b0;
          mPos[i]   = 0;
          mData[i]  = '0;
          mFresh[i] = 1'b0;
          mValid[i] = 1'b0;
        end else if (wasStop) begin
          mValid[i] = 1'b1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int inst,
                             input logic [127:0] got, input logic [127:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s inst%0d got %0h expected %0h", name, inst, got, want);
    end
  endtask

  task automatic compareAll();
    bit inWin;
    for (int i = 0; i < NI; i++) begin
      inWin = !mIdle[i] && (mPos[i] < WLS[i]);
      checkOutput("start", i, 128'(startA[i]), 128'(inWin && mPos[i] == 0));
      checkOutput("stop",  i, 128'(stopA[i]),  128'(inWin && mPos[i] == WLS[i] - 1));
      checkOutput("busy",  i, 128'(busyA[i]),  128'(inWin));
      checkOutput("done",  i, 128'(doneA[i]),  128'(mDone[i]));
      if (!mIdle[i] || mFresh[i])
        checkOutput("data", i, 128'(dataA[i]), 128'(mData[i]));
`ifdef SIGAN_SOURCE_EXPECT_EN
      checkOutput("valid", i, 128'(validA[i]), 128'(mValid[i]));
      if (mValid[i])
        checkOutput("expected", i, 128'(expA[i]), 128'(sigWord(WLS[i])));
      else if (mFresh[i])
        checkOutput("expected_rst", i, 128'(expA[i]), 128'd0);
`else
      checkOutput("valid", i, 128'(validA[i]), 128'd0);
      checkOutput("expected", i, 128'(expA[i]), 128'd0);
`endif
    end
  endtask

  // Drive inputs for the coming edge, then land mid-cycle after it and compare.
  task automatic applyStimulus(input logic runVal, input logic resetVal);
    run   = runVal;
    reset = resetVal;
    @(negedge clock);
    compareAll();
  endtask

  initial begin
    int starts[$];
    int stopAt;
    bit sawDone;

    // Model pins from hand-derived signatures.
    checkOutput("pin_w1c0", 0, 128'(sigOf(1, 0)), 128'h0000);
    checkOutput("pin_w2c0", 1, 128'(sigOf(2, 0)), 128'h0001);
    checkOutput("pin_w3c1", 2, 128'(sigOf(3, 1)), 128'h0001);
    checkOutput("pin_w8",   3, 128'(sigWord(8)),  128'h000F_0033_0055);

    // Reset.
    repeat (3) applyStimulus(1'b0, 1'b1);
    checkOutput("rst_data", 4, 128'(dataA[4]), 128'h00);
    checkOutput("rst_busy", 4, 128'(busyA[4]), 128'h0);

    // Single run pulse: WINDOW_LEN=1 gives start and stop together.
    applyStimulus(1'b1, 1'b0);
    checkOutput("w1_start", 0, 128'(startA[0]), 128'h1);
    checkOutput("w1_stop",  0, 128'(stopA[0]),  128'h1);
    checkOutput("w1_data",  0, 128'(dataA[0]),  128'h00);
    applyStimulus(1'b0, 1'b0);
    checkOutput("w1_done",  0, 128'(doneA[0]),  128'h1);
    repeat (10) applyStimulus(1'b0, 1'b0);
`ifdef SIGAN_SOURCE_EXPECT_EN
    checkOutput("w8_expected", 3, 128'(expA[3]), 128'h000F_0033_0055);
    checkOutput("w2_ch0", 1, 128'(expA[1][15:0]),  128'h0001);
    checkOutput("w3_ch1", 2, 128'(expA[2][31:16]), 128'h0001);
`else
    checkOutput("w8_expected", 3, 128'(expA[3]), 128'h0);
`endif

    // Continuous run: WINDOW_LEN=4, GAP_LEN=2 repeats every 6 clocks.
    for (int k = 1; k <= 30; k++) begin
      applyStimulus(1'b1, 1'b0);
      if (startA[4]) starts.push_back(k);
    end
    checkOutput("num_starts", 4, 128'(starts.size()), 128'd5);
    if (starts.size() >= 3) begin
      checkOutput("period1", 4, 128'(starts[1] - starts[0]), 128'd6);
      checkOutput("period2", 4, 128'(starts[2] - starts[1]), 128'd6);
    end
    repeat (12) applyStimulus(1'b0, 1'b0);

    // run dropped on the second window cycle: window still completes.
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    stopAt = -1;
    for (int k = 3; k <= 8; k++) begin
      applyStimulus(1'b0, 1'b0);
      if (stopA[4] && stopAt < 0) stopAt = k;
    end
    checkOutput("drop_stop_at", 4, 128'(stopAt), 128'd4);
    checkOutput("drop_busy",    4, 128'(busyA[4]), 128'h0);
    repeat (10) applyStimulus(1'b0, 1'b0);

    // Reset in the middle of a window aborts it with no done.
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("abort_busy",  4, 128'(busyA[4]),  128'h0);
    checkOutput("abort_start", 4, 128'(startA[4]), 128'h0);
    checkOutput("abort_data",  3, 128'(dataA[3]),  128'h00);
    checkOutput("abort_valid", 3, 128'(validA[3]), 128'h0);
    sawDone = 1'b0;
    repeat (10) begin
      applyStimulus(1'b0, 1'b0);
      if (doneA != '0) sawDone = 1'b1;
    end
    checkOutput("abort_no_done", 4, 128'(sawDone), 128'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sigan_source.md
# sigan_source

Stimulus transmitter for the signature-analyzer path: drives the probe side of the protocol (gate start/stop strobes plus a parallel data bus from a binary counter) so `sigan` channels can be exercised in-system and at board self-test. It emulates a unit-under-test address bus. An optional on-chip model computes the signature each channel should produce, so a check is a plain comparison. It sits between a control register (run/enable) and the `sigan` array; its outputs feed `sigan` start/stop/data directly.

## Interface
- `DATA_WIDTH`, 8: number of data channels (counter width).
- `WINDOW_LEN`, 1024: clocks per gate window, inclusive of start and stop cycles; legal range ≥1.
- `GAP_LEN`, 1024: idle clocks between windows in continuous mode; legal range ≥1.
- `COUNT_INIT`, 0: counter value loaded on the start cycle.
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `run`  in  1  level; high = keep producing windows, sampled each clock.
- `start`  out  1  one-cycle active-high strobe on the first window cycle.
- `stop`  out  1  one-cycle active-high strobe on the last window cycle.
- `data`  out  DATA_WIDTH  current counter value.
- `busy`  out  1  high from the start cycle through the stop cycle.
- `done`  out  1  one-cycle pulse on the cycle after `stop`.
- `expected`  out  16*DATA_WIDTH  per-channel signature; channel i in bits [16i+15:16i].
- `expected_valid`  out  1  high from `done` until the next `start` or reset.

## Operation
- States: IDLE, WINDOW, GAP.
- IDLE: `run` high → next cycle enters WINDOW (start cycle). Otherwise stay.
- WINDOW: on entry, counter = COUNT_INIT, window count = 0, models cleared, `start`=1. Each cycle counter += 1 (wraps mod 2^DATA_WIDTH), window count += 1. Cycle with window count = WINDOW_LEN-1 asserts `stop`, then → GAP if `run` high, else → IDLE.
- WINDOW_LEN=1: `start` and `stop` both high in the same single cycle.
- GAP: `start`/`stop` low; counter keeps incrementing; after GAP_LEN cycles → WINDOW if `run` high, else IDLE.
- `run` dropped mid-window: window completes normally (stop, done, expected), then IDLE. Never truncate a window.
- Signature model per channel: 16-bit register, polynomial x^16+x^12+x^9+x^7+1. Per window cycle: next = {sig[14:0], d ^ sig[6] ^ sig[8] ^ sig[11] ^ sig[15]}, d = `data[i]` of that cycle. Register cleared to 0 on the start cycle before that cycle's bit is shifted in. Every bit from start cycle through stop cycle inclusive is shifted (WINDOW_LEN bits).
- `expected` is held from `done` until the next start cycle, during which it may change.

## Timing
- Reset values: `start`=0, `stop`=0, `data`=COUNT_INIT, `busy`=0, `done`=0, `expected`=0, `expected_valid`=0, state IDLE.
- Reset mid-window: abort immediately; no `stop`, no `done`, `expected_valid` stays 0.
- `run` high in cycle N with state IDLE → `start` high in cycle N+1.
- `done` and `expected_valid` rise one cycle after `stop`.
- Continuous period = WINDOW_LEN + GAP_LEN clocks, start-to-start.

## Configuration
- `SIGAN_SOURCE_EXPECT_EN` defined: signature models and `expected`/`expected_valid` logic compiled in.
- Not defined: no model registers; `expected` tied to 0, `expected_valid` tied to 0. `done` and all other outputs unchanged.

## Structure
- `sigan_pkg`: SIG_WIDTH=16, tap constants (6, 8, 11, 15), state enum {IDLE, WINDOW, GAP}. Share these with `sigan`.
- One sub-module, `sigan_lfsr_model`: single-channel 16-bit register with clear, enable, and data input. Instantiated DATA_WIDTH times under the macro.

## Test plan
- WINDOW_LEN=1, pulse `run` once → one cycle with `start`=`stop`=1, `data`=00. Ch0 `expected`=0x0000, `done` next cycle.
- WINDOW_LEN=2 → ch0 bits 0,1 → 0x0001. WINDOW_LEN=3 → ch1 bits 0,0,1 → 0x0001.
- WINDOW_LEN=8 → ch0 = 0x0055; ch1 = 0x0033; ch2 = 0x000F; ch3–7 = 0x0000.
- `run` held high, WINDOW_LEN=4, GAP_LEN=2 → `start` every 6 clocks, `data` reloaded to 00 at each start, identical `expected` each window.
- `run` dropped on the second window cycle → window still ends with `stop` at cycle 4, then IDLE, `busy`=0.
- `reset` asserted mid-window → all outputs at reset values next cycle, no `done`.
